// File: rtl/rv_core_pkg.sv
// Shared definitions for the RISC-V core front end: opcodes, bubble word, fetch FSM states.
package rv_core_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  // addi x0,x0,0: decodes to the all-zero safe control set
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } ifid_t;

  // Clear the byte-offset bits of an address
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  // Opcode field of an instruction word
  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPC_W-1:0];
  endfunction

  // True for opcodes that access data memory
  function automatic logic is_mem_op(input logic [XLEN-1:0] instr);
    return (opcode_of(instr) == OP_LOAD) || (opcode_of(instr) == OP_STORE);
  endfunction

  // True for opcodes that can redirect the fetch stream or write a register from ALU
  function automatic logic is_branch_or_alu(input logic [XLEN-1:0] instr);
    return (opcode_of(instr) == OP_BRANCH) || (opcode_of(instr) == OP_RTYPE);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, sequential +4 (wrapping) and redirect load.
module fetch_pc_reg
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_target,
  input  logic [XLEN-1:0] target,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect wins over increment; the add wraps modulo 2^32
  always_comb begin
    pc_d = pc_q;
    if (load_target) begin
      pc_d = align_word(target);
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= align_word(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: imem request handshake, PC sequencing, IF/ID register with stall and redirect.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  ifid_t           ifid_q, ifid_d;
  logic            pc_load;
  logic            pc_inc;
  logic [XLEN-1:0] pc;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_target (pc_load),
    .target      (branch_target),
    .inc         (pc_inc),
    .pc          (pc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one outstanding request; redirect overrides stall everywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_gnt) state_d = WAIT;
      WAIT:  if (imem_rvalid) state_d = (kill_q || branch_taken) ? FETCH : HOLD;
      HOLD:  if (branch_taken || !stall) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    imem_req = (state_q == FETCH);
  end

  // Kill flag, IF/ID update and PC control
  always_comb begin
    kill_d  = kill_q;
    ifid_d  = ifid_q;
    pc_load = branch_taken;
    pc_inc  = 1'b0;
    case (state_q)
      FETCH: begin
        // Request already accepted at the old address: its response must be dropped
        if (branch_taken && imem_gnt) kill_d = 1'b1;
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (!kill_q && !branch_taken) begin
            ifid_d = '{instr: imem_rdata, pc: pc, valid: 1'b1};
            pc_inc = 1'b1;
          end
        end else if (branch_taken) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken || !stall) begin
          ifid_d = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Kill flag and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
      ifid_q <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
    end else begin
      kill_q <= kill_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr   = pc;
  assign Instruction = ifid_q.instr;
  assign instr_pc    = ifid_q.pc;
  assign instr_valid = ifid_q.valid;

endmodule
